bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 26 ++
 rtl/bus_arbiter_if.sv | 39 +++
 rtl/bus_arbiter_rr_pick.sv | 31 +++
 rtl/bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: bus widths, FSM state encoding
// and a small helper for sizing the round-robin pointer.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package bus_arbiter_pkg;

  localparam int ADDR_SIZE = `ADDR_SIZE;
  localparam int DATA_SIZE = `DATA_SIZE;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // Width of an index into n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// CPU-side and memory-side signals of the shared bus arbiter.
// master: the arbiter's view; slave: the CPUs/memory view.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int N_CPU = 4
);
  logic [N_CPU-1:0]           req_read;
  logic [N_CPU-1:0]           req_write;
  logic [N_CPU*ADDR_SIZE-1:0] cpu_addr;
  logic [N_CPU*DATA_SIZE-1:0] cpu_wdata;
  logic [N_CPU-1:0]           grant;
  logic                       bus_busy;
  logic [ADDR_SIZE-1:0]       mem_addr;
  logic [DATA_SIZE-1:0]       mem_wdata;
  logic                       mem_read_q;
  logic                       mem_write_q;
  logic                       mem_read_dn;
  logic                       mem_write_dn;
  logic [DATA_SIZE-1:0]       mem_rdata;
  logic [DATA_SIZE-1:0]       cpu_rdata;
  logic [N_CPU-1:0]           cpu_read_dn;
  logic [N_CPU-1:0]           cpu_write_dn;
  logic                       timeout_err;

  modport master (
    input  req_read, req_write, cpu_addr, cpu_wdata,
    input  mem_read_dn, mem_write_dn, mem_rdata,
    output grant, bus_busy, mem_addr, mem_wdata, mem_read_q, mem_write_q,
    output cpu_rdata, cpu_read_dn, cpu_write_dn, timeout_err
  );

  modport slave (
    output req_read, req_write, cpu_addr, cpu_wdata,
    output mem_read_dn, mem_write_dn, mem_rdata,
    input  grant, bus_busy, mem_addr, mem_wdata, mem_read_q, mem_write_q,
    input  cpu_rdata, cpu_read_dn, cpu_write_dn, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  // Scan the N positions starting at ptr and keep only the first hit.
  always_comb begin
    int j;
    j     = 0;
    pick  = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!valid && req[j]) begin
        pick[j] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving N_CPU CPUs access to a single memory bus.
// One transaction at a time: IDLE picks, ACCESS waits for the memory
// strobe (or times out), DONE returns the completion strobe to the CPU.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_CPU   = 4,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.master bus
);

  localparam int PW = ptr_width(N_CPU);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e           state_reg, state_next;
  logic [PW-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0]        gidx_reg, gidx_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [N_CPU-1:0]     grant_reg, grant_next;
  logic [N_CPU-1:0]     rdn_reg, rdn_next;
  logic [N_CPU-1:0]     wdn_reg, wdn_next;
  logic [ADDR_SIZE-1:0] addr_reg, addr_next;
  logic [DATA_SIZE-1:0] wdata_reg, wdata_next;
  logic [DATA_SIZE-1:0] rdata_reg, rdata_next;
  logic                 rq_reg, rq_next;
  logic                 wq_reg, wq_next;
  logic                 busy_reg, busy_next;
  logic                 to_reg, to_next;

  logic [N_CPU-1:0]     req_any;
  logic [N_CPU-1:0]     pick;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        ptr_after;
  logic [CW-1:0]        cnt_inc;
  logic                 done_rd;
  logic                 done_wr;

  for (genvar gi = 0; gi < N_CPU; gi++) begin : g_req
    assign req_any[gi] = bus.req_read[gi] | bus.req_write[gi];
  end

  rr_pick #(
    .N  (N_CPU),
    .PW (PW)
  ) u_rr_pick (
    .req   (req_any),
    .ptr   (rr_ptr_reg),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Encode the one-hot pick into an index for slicing the CPU buses.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
      end
    end
  end

  assign ptr_after = (gidx_reg == PW'(N_CPU - 1)) ? '0 : gidx_reg + 1'b1;
  assign cnt_inc   = cnt_reg + 1'b1;
  assign done_rd   = rq_reg & bus.mem_read_dn;
  assign done_wr   = wq_reg & bus.mem_write_dn;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    gidx_next   = gidx_reg;
    cnt_next    = cnt_reg;
    grant_next  = grant_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    rq_next     = rq_reg;
    wq_next     = wq_reg;
    rdn_next    = '0;
    wdn_next    = '0;
    to_next     = 1'b0;
    unique case (state_reg)
      ARB_IDLE: begin
        grant_next = '0;
        if (pick_valid) begin
          state_next = ARB_ACCESS;
          grant_next = pick;
          gidx_next  = pick_idx;
          cnt_next   = '0;
          addr_next  = bus.cpu_addr[int'(pick_idx)*ADDR_SIZE +: ADDR_SIZE];
          wdata_next = bus.cpu_wdata[int'(pick_idx)*DATA_SIZE +: DATA_SIZE];
          // A CPU asking for both gets its write first.
          wq_next    = bus.req_write[pick_idx];
          rq_next    = ~bus.req_write[pick_idx];
        end
      end
      ARB_ACCESS: begin
        if (done_rd || done_wr) begin
          state_next = ARB_DONE;
          rq_next    = 1'b0;
          wq_next    = 1'b0;
          rdn_next   = done_rd ? grant_reg : '0;
          wdn_next   = done_wr ? grant_reg : '0;
          if (done_rd) begin
            rdata_next = bus.mem_rdata;
          end
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            // Memory never answered: abort and let the next CPU in.
            state_next  = ARB_IDLE;
            rq_next     = 1'b0;
            wq_next     = 1'b0;
            grant_next  = '0;
            to_next     = 1'b1;
            rr_ptr_next = ptr_after;
          end
        end
      end
      ARB_DONE: begin
        state_next  = ARB_IDLE;
        grant_next  = '0;
        rr_ptr_next = ptr_after;
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
        rq_next    = 1'b0;
        wq_next    = 1'b0;
      end
    endcase
    busy_next = (state_next != ARB_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_IDLE;
      rr_ptr_reg <= '0;
      gidx_reg   <= '0;
      cnt_reg    <= '0;
      grant_reg  <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      rq_reg     <= 1'b0;
      wq_reg     <= 1'b0;
      rdn_reg    <= '0;
      wdn_reg    <= '0;
      busy_reg   <= 1'b0;
      to_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      gidx_reg   <= gidx_next;
      cnt_reg    <= cnt_next;
      grant_reg  <= grant_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      rq_reg     <= rq_next;
      wq_reg     <= wq_next;
      rdn_reg    <= rdn_next;
      wdn_reg    <= wdn_next;
      busy_reg   <= busy_next;
      to_reg     <= to_next;
    end
  end

  assign bus.grant        = grant_reg;
  assign bus.bus_busy     = busy_reg;
  assign bus.mem_addr     = addr_reg;
  assign bus.mem_wdata    = wdata_reg;
  assign bus.mem_read_q   = rq_reg;
  assign bus.mem_write_q  = wq_reg;
  assign bus.cpu_rdata    = rdata_reg;
  assign bus.cpu_read_dn  = rdn_reg;
  assign bus.cpu_write_dn = wdn_reg;
  assign bus.timeout_err  = to_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected transactions are queued when the
// CPU requests are driven and popped when the arbiter issues a grant.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int AW = ADDR_SIZE;
  localparam int DW = DATA_SIZE;

  typedef struct {
    int            cpu;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.N_CPU(N)) bus ();

  bus_arbiter #(
    .N_CPU   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  txn_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [AW-1:0] addr_tb [N];
  logic [DW-1:0] wdata_tb[N];
  logic [DW-1:0] last_rdata;
  txn_t          t;
  int            idle;
  int            cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_tb[i]  = a;
    wdata_tb[i] = d;
    bus.cpu_addr[i*AW +: AW]  = a;
    bus.cpu_wdata[i*DW +: DW] = d;
  endtask

  task automatic push(input int cpu, input bit wr, input logic [DW-1:0] rdata);
    txn_t e;
    e.cpu   = cpu;
    e.wr    = wr;
    e.addr  = addr_tb[cpu];
    e.wdata = wdata_tb[cpu];
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_busy"}, bus.bus_busy, 0);
    chk({tag, "_rq"}, bus.mem_read_q, 0);
    chk({tag, "_wq"}, bus.mem_write_q, 0);
    chk({tag, "_rdn"}, bus.cpu_read_dn, 0);
    chk({tag, "_wdn"}, bus.cpu_write_dn, 0);
    chk({tag, "_to"}, bus.timeout_err, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_rdata"}, bus.cpu_rdata, 0);
  endtask

  // Wait (bounded) for a grant, then pop the scoreboard and check it.
  task automatic wait_grant(output txn_t tr, output int idle_cycles);
    bit got;
    got         = 1'b0;
    idle_cycles = 0;
    tr          = '{cpu: 0, wr: 1'b0, addr: '0, wdata: '0, rdata: '0};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        got = 1'b1;
        break;
      end
      idle_cycles++;
      chk("idle_dn", {bus.cpu_read_dn, bus.cpu_write_dn}, 0);
      chk("idle_busy", bus.bus_busy, 0);
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard observed=empty expected=pending transaction");
      return;
    end
    tr = exp_q.pop_front();
    if (!got) begin
      total++;
      bad++;
      $display("FAIL grant_wait observed=no grant expected=grant to cpu %0d", tr.cpu);
      return;
    end
    $display("grant cpu=%0d %s addr=%0h", tr.cpu, tr.wr ? "write" : "read", bus.mem_addr);
    chk("grant", bus.grant, onehot(tr.cpu));
    chk("mem_q", {bus.mem_read_q, bus.mem_write_q}, {~tr.wr, tr.wr});
    chk("mem_addr", bus.mem_addr, tr.addr);
    chk("mem_wdata", bus.mem_wdata, tr.wdata);
    chk("busy_access", bus.bus_busy, 1);
  endtask

  // Hold memory off for `latency` cycles (optionally with the wrong strobe),
  // then complete and check the CPU-side completion.
  task automatic finish_txn(input txn_t tr, input int latency, input bit wrong_dn);
    for (int k = 0; k < latency; k++) begin
      if (wrong_dn) begin
        if (tr.wr) bus.mem_read_dn = 1'b1;
        else       bus.mem_write_dn = 1'b1;
      end
      @(negedge clk);
      bus.mem_read_dn  = 1'b0;
      bus.mem_write_dn = 1'b0;
      chk("hold_q", {bus.mem_read_q, bus.mem_write_q}, {~tr.wr, tr.wr});
      chk("hold_grant", bus.grant, onehot(tr.cpu));
      chk("hold_dn", {bus.cpu_read_dn, bus.cpu_write_dn}, 0);
    end
    if (tr.wr) begin
      bus.mem_write_dn = 1'b1;
    end else begin
      bus.mem_read_dn = 1'b1;
      bus.mem_rdata   = tr.rdata;
    end
    @(negedge clk);
    bus.mem_read_dn  = 1'b0;
    bus.mem_write_dn = 1'b0;
    bus.mem_rdata    = DW'($urandom());
    if (!tr.wr) last_rdata = tr.rdata;
    $display("done  cpu=%0d %s rdata=%0h", tr.cpu, tr.wr ? "write" : "read", bus.cpu_rdata);
    chk("cpu_read_dn", bus.cpu_read_dn, tr.wr ? '0 : onehot(tr.cpu));
    chk("cpu_write_dn", bus.cpu_write_dn, tr.wr ? onehot(tr.cpu) : '0);
    chk("done_q", {bus.mem_read_q, bus.mem_write_q}, 0);
    chk("busy_done", bus.bus_busy, 1);
    chk("cpu_rdata", bus.cpu_rdata, last_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.req_read     = '0;
    bus.req_write    = '0;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
    bus.mem_read_dn  = 1'b0;
    bus.mem_write_dn = 1'b0;
    bus.mem_rdata    = '0;
    last_rdata       = '0;
    for (int i = 0; i < N; i++) set_cpu(i, '0, '0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single read from CPU2, then CPU0/CPU3 show rr_ptr moved to 3.
    set_cpu(2, 16'h0010, 32'h2222_0000);
    bus.req_read = 4'b0100;
    push(2, 1'b0, 32'h0000_00AB);
    wait_grant(t, idle);
    finish_txn(t, 0, 1'b0);
    set_cpu(0, 16'h0030, 32'h0);
    set_cpu(3, 16'h0033, 32'h0);
    bus.req_read = 4'b1001;
    push(3, 1'b0, 32'h3333_0001);
    push(0, 1'b0, 32'h0000_0002);
    wait_grant(t, idle);
    finish_txn(t, 1, 1'b0);
    bus.req_read = 4'b0001;
    wait_grant(t, idle);
    finish_txn(t, 0, 1'b0);
    bus.req_read = 4'b0000;

    // Reset clears the pointer; all four writers are then served in order.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    last_rdata = '0;
    chk_all_zero("reset2");
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_cpu(i, AW'(16'h0100 + i), DW'(32'hD0 + i));
    bus.req_write = 4'b1111;
    for (int i = 0; i < 5; i++) push(i % N, 1'b1, '0);
    for (int i = 0; i < 5; i++) begin
      wait_grant(t, idle);
      if (i > 0) chk("idle_gap", (idle >= 1), 1);
      finish_txn(t, i % 3, (i == 2));
    end
    bus.req_write = 4'b0000;

    // CPU1 asks for both: write is served first, then the read.
    set_cpu(1, 16'h0200, 32'h1111_5555);
    bus.req_read  = 4'b0010;
    bus.req_write = 4'b0010;
    push(1, 1'b1, '0);
    push(1, 1'b0, 32'h5A5A_A5A5);
    wait_grant(t, idle);
    finish_txn(t, 0, 1'b0);
    bus.req_write = 4'b0000;
    wait_grant(t, idle);
    finish_txn(t, 0, 1'b0);
    bus.req_read = 4'b0000;

    // Memory never answers CPU2's read: timeout, then CPU3 is granted.
    set_cpu(2, 16'h0222, 32'h0);
    set_cpu(3, 16'h0333, 32'h3030_3030);
    bus.req_read  = 4'b0100;
    bus.req_write = 4'b1000;
    push(2, 1'b0, '0);
    push(3, 1'b1, '0);
    wait_grant(t, idle);
    bus.req_read = 4'b0000;
    cnt = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_read_q) cnt++;
      else break;
    end
    $display("timeout after %0d access cycles, timeout_err=%0b", cnt, bus.timeout_err);
    chk("to_cycles", cnt, TO);
    chk("to_pulse", bus.timeout_err, 1);
    chk("to_grant", bus.grant, 0);
    chk("to_q", {bus.mem_read_q, bus.mem_write_q}, 0);
    chk("to_dn", {bus.cpu_read_dn, bus.cpu_write_dn}, 0);
    wait_grant(t, idle);
    chk("to_pulse_len", bus.timeout_err, 0);
    finish_txn(t, 0, 1'b0);
    bus.req_write = 4'b0000;

    // Read with a stray write strobe: completes only on the read strobe.
    set_cpu(1, 16'h0201, 32'h0);
    bus.req_read = 4'b0010;
    push(1, 1'b0, 32'h00C0_FFEE);
    wait_grant(t, idle);
    finish_txn(t, 2, 1'b1);
    bus.req_read = 4'b0000;

    // Reset in the middle of CPU2's access; CPU0 then wins from rr_ptr=0.
    bus.req_read = 4'b0100;
    push(2, 1'b0, '0);
    wait_grant(t, idle);
    bus.req_read = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    bus.req_write = 4'b1001;
    @(negedge clk);
    last_rdata = '0;
    chk_all_zero("rst_access");
    rst = 1'b0;
    push(0, 1'b1, '0);
    push(3, 1'b1, '0);
    wait_grant(t, idle);
    finish_txn(t, 0, 1'b0);
    bus.req_write = 4'b1000;
    wait_grant(t, idle);
    finish_txn(t, 0, 1'b0);
    bus.req_write = 4'b0000;

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
